// File: rtl/counter_fifo_gen_if.sv
// Bus bundle for counter_fifo_gen: write/read requests and counter clear in,
// read data, live counter, occupancy counts and status flags out.
interface counter_fifo_gen_if #(
  parameter int DATA_WIDTH = 20,
  parameter int DEPTH      = 64
);
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

  logic                  en;
  logic                  rd_en;
  logic                  clr_cnt;
  logic [DATA_WIDTH-1:0] Q;
  logic                  RDVALID;
  logic [DATA_WIDTH-1:0] CNT;
  logic                  FULL;
  logic                  EMPTY;
  logic                  AFULL;
  logic                  AEMPTY;
  logic                  OVERFLOW;
  logic                  UNDERFLOW;
  logic [CNT_WIDTH-1:0]  WRCNT;
  logic [CNT_WIDTH-1:0]  RDCNT;

  modport master (
    output en, rd_en, clr_cnt,
    input  Q, RDVALID, CNT, FULL, EMPTY, AFULL, AEMPTY,
           OVERFLOW, UNDERFLOW, WRCNT, RDCNT
  );

  modport slave (
    input  en, rd_en, clr_cnt,
    output Q, RDVALID, CNT, FULL, EMPTY, AFULL, AEMPTY,
           OVERFLOW, UNDERFLOW, WRCNT, RDCNT
  );
endinterface

// File: rtl/counter_fifo_gen.sv
// Pattern source for bring-up: a stepping up-counter pushes its value into a
// single-clock FIFO with a registered read port and occupancy-derived flags.
module counter_fifo_gen #(
  parameter int          DATA_WIDTH    = 20,
  parameter int          DEPTH         = 64,
  parameter int unsigned STEP          = 1,
  parameter int          AFULL_TH      = DEPTH - 4,
  parameter int          AEMPTY_TH     = 4,
  parameter bit          STALL_ON_FULL = 1'b0
) (
  input logic               CLK,
  input logic               RESET,
  counter_fifo_gen_if.slave bus
);
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int CNT_WIDTH = ADDR_W + 1;

  localparam logic [CNT_WIDTH-1:0]  DEPTH_C  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  AFULL_C  = CNT_WIDTH'(AFULL_TH);
  localparam logic [CNT_WIDTH-1:0]  AEMPTY_C = CNT_WIDTH'(AEMPTY_TH);
  localparam logic [DATA_WIDTH-1:0] STEP_C   = DATA_WIDTH'(STEP);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [CNT_WIDTH-1:0]  occ;
  logic [DATA_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] cnt_d;
  logic [DATA_WIDTH-1:0] q_q;
  logic                  rdvalid_q;
  logic                  ovf_q;
  logic                  udf_q;
  logic                  full;
  logic                  empty;
  logic                  wr_ok;
  logic                  rd_ok;

  // Flags come from the occupancy register, so pointer wrap never aliases
  // full with empty.
  assign full  = (occ == DEPTH_C);
  assign empty = (occ == '0);

  // A read frees a slot in the same cycle, so a full FIFO still accepts a
  // write alongside it; there is no fall-through on an empty FIFO.
  assign rd_ok = bus.rd_en & ~empty;
  assign wr_ok = bus.en & (~full | rd_ok);

  // NOTE: every variable driven here gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_cnt) begin
      cnt_d = '0;
    end else if (bus.en & (wr_ok | ~STALL_ON_FULL)) begin
      cnt_d = cnt_q + STEP_C;
    end
  end

  // NOTE: storage array has no reset; clearing pointers and occupancy is what
  // empties the FIFO, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge CLK) begin
    if (!RESET && wr_ok) begin
      mem[wr_ptr] <= cnt_q;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      rdvalid_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        q_q    <= mem[rd_ptr];
      end
      rdvalid_q <= rd_ok;
      ovf_q     <= bus.en & ~wr_ok;
      udf_q     <= bus.rd_en & ~rd_ok;
      cnt_q     <= cnt_d;
      unique case ({wr_ok, rd_ok})
        2'b10:   occ <= occ + CNT_WIDTH'(1);
        2'b01:   occ <= occ - CNT_WIDTH'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign bus.Q         = q_q;
  assign bus.RDVALID   = rdvalid_q;
  assign bus.CNT       = cnt_q;
  assign bus.FULL      = full;
  assign bus.EMPTY     = empty;
  assign bus.AFULL     = (occ >= AFULL_C);
  assign bus.AEMPTY    = (occ <= AEMPTY_C);
  assign bus.OVERFLOW  = ovf_q;
  assign bus.UNDERFLOW = udf_q;
  assign bus.WRCNT     = occ;
  assign bus.RDCNT     = DEPTH_C - occ;
endmodule

// File: tb/tb_counter_fifo_gen.sv
// Two counter_fifo_gen configurations (default drop mode; small 4-bit stall
// mode with STEP=3) checked against a queue-based reference model.
module tb_counter_fifo_gen;
  typedef struct {
    logic [31:0] q;
    logic        rdvalid;
    logic [31:0] cnt;
    logic [31:0] wrcnt;
    logic [31:0] rdcnt;
    logic        full;
    logic        empty;
    logic        afull;
    logic        aempty;
    logic        ovf;
    logic        udf;
  } status_t;

  // Per-instance configuration: index 0 = dut_a, index 1 = dut_b.
  int cfg_dw    [2] = '{20, 4};
  int cfg_depth [2] = '{64, 4};
  int cfg_step  [2] = '{1, 3};
  int cfg_af    [2] = '{60, 3};
  int cfg_ae    [2] = '{4, 1};
  bit cfg_stall [2] = '{1'b0, 1'b1};

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  counter_fifo_gen_if #(.DATA_WIDTH(20), .DEPTH(64)) bus_a ();
  counter_fifo_gen_if #(.DATA_WIDTH(4),  .DEPTH(4))  bus_b ();

  counter_fifo_gen #(
    .DATA_WIDTH(20), .DEPTH(64), .STEP(1), .AFULL_TH(60), .AEMPTY_TH(4), .STALL_ON_FULL(1'b0)
  ) dut_a (.CLK(CLK), .RESET(RESET), .bus(bus_a));

  counter_fifo_gen #(
    .DATA_WIDTH(4), .DEPTH(4), .STEP(3), .AFULL_TH(3), .AEMPTY_TH(1), .STALL_ON_FULL(1'b1)
  ) dut_b (.CLK(CLK), .RESET(RESET), .bus(bus_b));

  int tests = 0;
  int fails = 0;

  // Reference model state: stored words as a plain queue, counter as an int.
  int unsigned fifo_m  [2][$];
  int unsigned cnt_m   [2];
  int unsigned qlast_m [2];
  int unsigned rd_exp  [2][$];
  status_t     st_exp  [2][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input bit rst, input bit en, input bit rd, input bit clr);
    status_t     s;
    int unsigned mask;
    int          occ;
    bit          rd_ok;
    bit          wr_ok;
    mask = (32'd1 << cfg_dw[i]) - 32'd1;
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    if (rst) begin
      fifo_m[i].delete();
      cnt_m[i]   = 0;
      qlast_m[i] = 0;
    end else begin
      occ   = fifo_m[i].size();
      rd_ok = rd && (occ != 0);
      wr_ok = en && ((occ != cfg_depth[i]) || rd_ok);
      if (rd_ok) begin
        qlast_m[i] = fifo_m[i].pop_front();
        rd_exp[i].push_back(qlast_m[i]);
      end
      if (wr_ok) fifo_m[i].push_back(cnt_m[i]);
      if (clr) cnt_m[i] = 0;
      else if (en && (wr_ok || !cfg_stall[i])) cnt_m[i] = (cnt_m[i] + cfg_step[i]) & mask;
    end
    s.q       = qlast_m[i];
    s.rdvalid = rd_ok;
    s.cnt     = cnt_m[i];
    s.wrcnt   = 32'(fifo_m[i].size());
    s.rdcnt   = 32'(cfg_depth[i] - fifo_m[i].size());
    s.full    = (fifo_m[i].size() == cfg_depth[i]);
    s.empty   = (fifo_m[i].size() == 0);
    s.afull   = (fifo_m[i].size() >= cfg_af[i]);
    s.aempty  = (fifo_m[i].size() <= cfg_ae[i]);
    s.ovf     = !rst && en && !wr_ok;
    s.udf     = !rst && rd && !rd_ok;
    st_exp[i].push_back(s);
  endtask

  task automatic monitor(input int i, input status_t act);
    status_t e;
    string   p;
    p = (i == 0) ? "a" : "b";
    if (st_exp[i].size() != 0) begin
      e = st_exp[i].pop_front();
      check({p, ".Q"},         act.q,       e.q);
      check({p, ".RDVALID"},   32'(act.rdvalid), 32'(e.rdvalid));
      check({p, ".CNT"},       act.cnt,     e.cnt);
      check({p, ".WRCNT"},     act.wrcnt,   e.wrcnt);
      check({p, ".RDCNT"},     act.rdcnt,   e.rdcnt);
      check({p, ".FULL"},      32'(act.full),   32'(e.full));
      check({p, ".EMPTY"},     32'(act.empty),  32'(e.empty));
      check({p, ".AFULL"},     32'(act.afull),  32'(e.afull));
      check({p, ".AEMPTY"},    32'(act.aempty), 32'(e.aempty));
      check({p, ".OVERFLOW"},  32'(act.ovf),    32'(e.ovf));
      check({p, ".UNDERFLOW"}, 32'(act.udf),    32'(e.udf));
    end
    if (act.rdvalid) begin
      if (rd_exp[i].size() == 0) check({p, ".rdvalid_no_read"}, 32'(act.rdvalid), 32'd0);
      else                       check({p, ".rd_data"}, act.q, rd_exp[i].pop_front());
    end
  endtask

  // Monitors sample on the falling edge, half a cycle after outputs settle.
  always @(negedge CLK) begin
    status_t a;
    a.q = 32'(bus_a.Q);         a.rdvalid = bus_a.RDVALID; a.cnt = 32'(bus_a.CNT);
    a.wrcnt = 32'(bus_a.WRCNT); a.rdcnt = 32'(bus_a.RDCNT);
    a.full = bus_a.FULL;        a.empty = bus_a.EMPTY;     a.afull = bus_a.AFULL;
    a.aempty = bus_a.AEMPTY;    a.ovf = bus_a.OVERFLOW;    a.udf = bus_a.UNDERFLOW;
    monitor(0, a);
  end

  always @(negedge CLK) begin
    status_t b;
    b.q = 32'(bus_b.Q);         b.rdvalid = bus_b.RDVALID; b.cnt = 32'(bus_b.CNT);
    b.wrcnt = 32'(bus_b.WRCNT); b.rdcnt = 32'(bus_b.RDCNT);
    b.full = bus_b.FULL;        b.empty = bus_b.EMPTY;     b.afull = bus_b.AFULL;
    b.aempty = bus_b.AEMPTY;    b.ovf = bus_b.OVERFLOW;    b.udf = bus_b.UNDERFLOW;
    monitor(1, b);
  end

  task automatic apply(input bit rst, input bit en0, input bit rd0, input bit clr0,
                       input bit en1, input bit rd1, input bit clr1);
    @(negedge CLK);
    #1;
    RESET = rst;
    bus_a.en = en0; bus_a.rd_en = rd0; bus_a.clr_cnt = clr0;
    bus_b.en = en1; bus_b.rd_en = rd1; bus_b.clr_cnt = clr1;
    model_step(0, rst, en0, rd0, clr0);
    model_step(1, rst, en1, rd1, clr1);
  endtask

  task automatic drive(input bit rst, input bit en, input bit rd, input bit clr, input int n);
    repeat (n) apply(rst, en, rd, clr, en, rd, clr);
  endtask

  // One idle cycle; registered outputs seen afterwards reflect the prior edge.
  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int en_pct [4] = '{70, 30, 50, 90};
  int rd_pct [4] = '{30, 70, 50, 90};

  initial begin
    bus_a.en = 1'b0; bus_a.rd_en = 1'b0; bus_a.clr_cnt = 1'b0;
    bus_b.en = 1'b0; bus_b.rd_en = 1'b0; bus_b.clr_cnt = 1'b0;

    // Fill past full in drop mode, then drain one past empty.
    drive(1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 67);
    idle();
    check("a.fill_cnt",   32'(bus_a.CNT),   32'd67);
    check("a.fill_wrcnt", 32'(bus_a.WRCNT), 32'd64);
    check("a.fill_rdcnt", 32'(bus_a.RDCNT), 32'd0);
    drive(0, 0, 1, 0, 65);
    idle();
    check("a.drain_udf",   32'(bus_a.UNDERFLOW), 32'd1);
    check("a.drain_empty", 32'(bus_a.EMPTY),     32'd1);

    // Simultaneous read/write at full, then at empty.
    drive(0, 1, 0, 0, 64);
    drive(0, 1, 1, 0, 10);
    idle();
    check("a.simul_wrcnt", 32'(bus_a.WRCNT),    32'd64);
    check("a.simul_ovf",   32'(bus_a.OVERFLOW), 32'd0);
    drive(0, 0, 1, 0, 64);
    drive(0, 1, 1, 0, 1);
    idle();
    check("a.empty_both_udf",   32'(bus_a.UNDERFLOW), 32'd1);
    check("a.empty_both_wrcnt", 32'(bus_a.WRCNT),     32'd1);

    // Counter clear together with a write, observed on the 4-bit instance.
    drive(1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 3);
    drive(0, 1, 0, 1, 1);
    idle();
    check("b.clr_cnt",   32'(bus_b.CNT),   32'd0);
    check("b.clr_wrcnt", 32'(bus_b.WRCNT), 32'd4);
    drive(0, 0, 1, 0, 5);

    // Reset mid-run with a read outstanding.
    drive(1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 30);
    drive(0, 0, 1, 0, 1);
    drive(1, 0, 1, 0, 1);
    idle();
    check("a.rst_rdvalid", 32'(bus_a.RDVALID), 32'd0);
    check("a.rst_wrcnt",   32'(bus_a.WRCNT),   32'd0);
    check("a.rst_rdcnt",   32'(bus_a.RDCNT),   32'd64);
    check("a.rst_cnt",     32'(bus_a.CNT),     32'd0);
    drive(0, 0, 1, 0, 1);
    idle();
    check("a.rst_then_udf", 32'(bus_a.UNDERFLOW), 32'd1);

    // Randomised traffic with biased phases to reach both full and empty.
    for (int seg = 0; seg < 4; seg++) begin
      for (int n = 0; n < 800; n++) begin
        apply($urandom_range(999) < 3,
              $urandom_range(99) < en_pct[seg], $urandom_range(99) < rd_pct[seg],
              $urandom_range(99) < 3,
              $urandom_range(99) < en_pct[seg], $urandom_range(99) < rd_pct[seg],
              $urandom_range(99) < 3);
      end
    end

    drive(0, 0, 0, 0, 2);
    @(negedge CLK);
    #1;
    check("a.rd_pending", 32'(rd_exp[0].size()), 32'd0);
    check("b.rd_pending", 32'(rd_exp[1].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/counter_fifo_gen.md
Name: counter_fifo_gen

Overview:
Parametrised pattern source and buffer for fabric bring-up: an enable-driven up-counter writes its value into a single-clock synchronous FIFO.
A read port drains the FIFO with registered data and a valid strobe. Occupancy and free-space counts are exported, as are full, empty, almost-full, almost-empty, overflow and underflow flags.
Generalises the fixed 20-bit counter/FIFO pair with these additions:
- configurable width, depth, step and thresholds
- selectable drop-or-stall behaviour on full
- counter clear
- read valid strobe

Parameters:
DATA_WIDTH, 20, counter and FIFO word width (2..32)
DEPTH, 64, FIFO depth in words; power of two, 4..1024
CNT_WIDTH, $clog2(DEPTH)+1, width of count outputs (derived; not overridden)
STEP, 1, counter increment per accepted en, 1..2^DATA_WIDTH-1
AFULL_TH, DEPTH-4, AFULL asserts when occupancy >= AFULL_TH
AEMPTY_TH, 4, AEMPTY asserts when occupancy <= AEMPTY_TH
STALL_ON_FULL, 0, 0 = drop sample but advance counter when full; 1 = hold counter when full

Ports:
CLK  in  1  single clock, rising edge
RESET  in  1  synchronous active-high reset
en  in  1  write request: push current CNT into FIFO
rd_en  in  1  read request
clr_cnt  in  1  synchronous counter clear; FIFO contents untouched
Q  out  DATA_WIDTH  registered read data
RDVALID  out  1  Q updated this cycle
CNT  out  DATA_WIDTH  current counter value
FULL  out  1  occupancy == DEPTH
EMPTY  out  1  occupancy == 0
AFULL  out  1  occupancy >= AFULL_TH
AEMPTY  out  1  occupancy <= AEMPTY_TH
OVERFLOW  out  1  one-cycle pulse: en rejected
UNDERFLOW  out  1  one-cycle pulse: rd_en rejected
WRCNT  out  CNT_WIDTH  occupancy (words stored)
RDCNT  out  CNT_WIDTH  free space (DEPTH - occupancy)

Behaviour:
Reset:
- Reset is synchronous, active-high and overrides everything.
- Reset values: Q=0, RDVALID=0, CNT=0, WRCNT=0, RDCNT=DEPTH, EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, OVERFLOW=0, UNDERFLOW=0.
- Read/write pointers are cleared. Reset mid-operation discards all contents the same edge.

Write acceptance (wr_ok):
- wr_ok = en & (!FULL | rd_ok).
- Writing into a full FIFO is legal when a read is accepted in the same cycle.
- Accepted write stores the current CNT; the pointer advances modulo DEPTH.

Read acceptance (rd_ok):
- rd_ok = rd_en & !EMPTY. There is no fall-through: a write and read in the same cycle on an empty FIFO gives UNDERFLOW=1, and the written word is stored.
- Accepted read: Q <= mem[rd_ptr] and RDVALID=1 on the next edge (latency 1). Q holds its last value otherwise; RDVALID=0.

Counter:
- Next CNT, in priority order:
  - clr_cnt: 0
  - en & (wr_ok | !STALL_ON_FULL): CNT+STEP modulo 2^DATA_WIDTH (natural wrap)
  - otherwise: CNT holds
- clr_cnt with en: the pre-clear CNT is written; next CNT=0.
- STALL_ON_FULL=0: a rejected en still advances CNT, so dropped samples show as gaps in Q.
- STALL_ON_FULL=1: a rejected en holds CNT, so the data sequence is gap-free.

Error pulses:
- OVERFLOW registered: 1 for one cycle after an edge where en & !wr_ok.
- UNDERFLOW registered: 1 for one cycle after an edge where rd_en & !rd_ok.
- Back-to-back errors give OVERFLOW/UNDERFLOW high continuously.

Occupancy and flags:
- Occupancy register: +1 on wr only, -1 on rd only, unchanged on both or neither.
- Occupancy never exceeds DEPTH and never goes below 0.
- FULL, EMPTY, AFULL, AEMPTY, WRCNT and RDCNT are decoded from the registered occupancy. They change on the same edge as the occupancy update, with no extra cycle.
- WRCNT + RDCNT == DEPTH always.

Pointer wrap:
- Pointers are $clog2(DEPTH) bits.
- FULL/EMPTY come from occupancy, not pointer comparison, so they are wrap-safe.

Test Plan:
- Fill (defaults): RESET 1 cycle, then en=1 for 64 cycles, rd_en=0 -> WRCNT 0..64, FULL=1 after the 64th edge, AFULL at WRCNT=60, RDCNT=0, OVERFLOW=0.
- Drop mode: continue en 3 more cycles on full -> OVERFLOW=1 for 3 cycles, CNT=67, WRCNT=64. Drain 64 reads -> Q=0..63 with RDVALID each cycle after rd_en. 65th read -> UNDERFLOW=1, EMPTY=1.
- Stall mode (STALL_ON_FULL=1, DEPTH=4): 6 en pulses -> OVERFLOW 2 cycles, CNT=4. Drain -> Q=0,1,2,3. Next en writes 4.
- Simultaneous: at FULL, en=1 & rd_en=1 for 10 cycles -> WRCNT stays 64, OVERFLOW=0, Q continuous. At EMPTY, both=1 -> UNDERFLOW=1, WRCNT=1.
- Wrap and clear (DATA_WIDTH=4, STEP=3): 6 writes -> stored 0,3,6,9,12,15, CNT=2. clr_cnt with en -> writes 2, CNT=0.
- Reset mid-run: RESET while WRCNT=30 and a read is in flight -> next cycle all outputs at reset values, RDVALID=0, a subsequent read -> UNDERFLOW.
